// File: rtl/hilo_mult_unit.sv
// HI/LO architectural register pair with an iterative shift-add multiplier.
// mthi/mtlo write in a single cycle; mult/multu/madd/msub take WIDTH steps
// plus one finish cycle, with Busy/Done as the pipeline stall handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Start; mthi/mtlo complete here
// MUL   | one shift-add step per cycle, WIDTH steps in total
// FIN   | sign-correct the product and write/accumulate into HI/LO
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_MADD  = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t               state, state_nxt;
    logic                 wr_hi, wr_lo, start_mul, finish;
    logic [WIDTH-1:0]     mcand, mplier;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        cnt;
    logic [2:0]           op_q;
    logic                 sign_q;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   p_final, acc, result;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
    assign signed_op = (Op != OP_MULTU);
    assign a_mag     = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_mag     = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // Upper half plus multiplicand, one carry bit wide, for the current step.
    assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};

    assign p_final   = sign_q ? (~prod + 1'b1) : prod;
    assign acc       = {Hi, Lo};

    // Final HI/LO value depending on whether this is a plain or accumulating multiply.
    always_comb begin
        result = p_final;
        case (op_q)
            OP_MADD: result = acc + p_final;
            OP_MSUB: result = acc - p_final;
            default: result = p_final;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        start_mul = 1'b0;
        finish    = 1'b0;
        Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            start_mul = 1'b1;
                            state_nxt = MUL;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
            end
            FIN: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO registers, Done pulse and the multiplier datapath.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Hi     <= '0;
            Lo     <= '0;
            Done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
        end else begin
            Done <= finish;
            if (wr_hi) Hi <= A;
            if (wr_lo) Lo <= A;
            if (start_mul) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                sign_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                op_q   <= Op;
                prod   <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                prod   <= {step_sum, prod[WIDTH-1:1]};
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (finish) {Hi, Lo} <= result;
        end
    end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Bench for hilo_mult_unit: an ordered vector table with hand-computed HI/LO
// results, a Done-driven scoreboard, and hand sequences for busy/reset cases.
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  A, B;
    logic [W-1:0]  Hi, Lo;
    logic          Busy, Done;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[16];

    hilo_mult_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each Done pulse must match the oldest pending multiply result.
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_hilo", {Hi, Lo}, e);
            end
        end
    end

    function automatic bit is_mul(input logic [2:0] op);
        return (op >= 3'd3) && (op <= 3'd6);
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        Start = 1'b1; Op = v.op; A = v.a; B = v.b;
        @(posedge Clk); #1;
        Start = 1'b0;
        if (is_mul(v.op)) begin
            sb_q.push_back({v.hi, v.lo});
            n = 0;
            while (Busy && n < 40) begin
                A = $urandom; B = $urandom;
                n++;
                @(posedge Clk); #1;
            end
            check($sformatf("busy_cycles[%0d]", idx), 64'(n), 64'd33);
            check($sformatf("done_hi[%0d]", idx), {63'd0, Done}, 64'd1);
            check($sformatf("hilo[%0d]", idx), {Hi, Lo}, {v.hi, v.lo});
            @(posedge Clk); #1;
            check($sformatf("done_lo[%0d]", idx), {63'd0, Done}, 64'd0);
        end else begin
            check($sformatf("hilo[%0d]", idx), {Hi, Lo}, {v.hi, v.lo});
            check($sformatf("busy0[%0d]", idx), {62'd0, Busy, Done}, 64'd0);
        end
    endtask

    initial begin
        bit seen_done;
        int n;

        vecs[0]  = '{3'd1, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000};
        vecs[1]  = '{3'd2, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D};
        vecs[2]  = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[3]  = '{3'd3, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[4]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5]  = '{3'd1, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000};
        vecs[6]  = '{3'd2, 32'h00000005, 32'h0,        32'h00000000, 32'h00000005};
        vecs[7]  = '{3'd5, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000011};
        vecs[8]  = '{3'd2, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000};
        vecs[9]  = '{3'd6, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[10] = '{3'd5, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[11] = '{3'd4, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[12] = '{3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF};
        vecs[13] = '{3'd0, 32'h00000123, 32'h456,      32'h00000001, 32'h7FFFFFFF};
        vecs[14] = '{3'd7, 32'h00000123, 32'h456,      32'h00000001, 32'h7FFFFFFF};
        vecs[15] = '{3'd3, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};

        Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
        #2;
        check("reset_state", {Hi, Lo, 30'd0, Busy, Done}, 96'd0);
        #20 Reset = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Start held through the busy window and the finish edge is ignored,
        // then accepted on the following edge.
        Start = 1'b1; Op = 3'd3; A = 32'd3; B = 32'd5;
        @(posedge Clk); #1;
        Start = 1'b0;
        sb_q.push_back(64'd15);
        for (int c = 1; c < 10; c++) begin @(posedge Clk); #1; end
        Start = 1'b1; Op = 3'd1; A = 32'h0000DEAD;
        n = 10;
        while (Busy && n < 45) begin @(posedge Clk); #1; n++; end
        check("busy_start_ignored", {Hi, Lo}, 64'd15);
        check("fin_done", {63'd0, Done}, 64'd1);
        @(posedge Clk); #1;
        Start = 1'b0;
        check("accept_after_fin", {32'd0, Hi}, 64'h0000DEAD);

        // Asynchronous reset in the middle of a multiply.
        Start = 1'b1; Op = 3'd1; A = 32'h0000AAAA;
        @(posedge Clk); #1;
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd200;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int c = 0; c < 20; c++) begin @(posedge Clk); #1; end
        check("busy_before_reset", {63'd0, Busy}, 64'd1);
        #2 Reset = 1'b1;
        #1 check("async_reset", {Hi, Lo, 30'd0, Busy, Done}, 96'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge Clk); #1;
            if (Done) seen_done = 1'b1;
        end
        check("no_done_after_reset", {63'd0, seen_done}, 64'd0);
        check("hilo_after_reset", {Hi, Lo}, 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Owns the architectural HI/LO register pair that the datapath ALU reads and writes.
- Supplies the current HI/LO values to the ALU for mfhi/mflo.
- Accepts mthi/mtlo writes.
- Executes mult, multu, madd and msub with an iterative 32-step shift-add multiplier. The pipeline uses the Busy/Done handshake to stall.

Parameters:
- WIDTH, 32, operand and HI/LO register width. The product is 2*WIDTH bits and the iteration count is WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; sampled only while Busy=0.
- Op  input  3  operation code: 0 none, 1 mthi, 2 mtlo, 3 mult (signed), 4 multu, 5 madd (signed), 6 msub (signed), 7 reserved.
- A  input  WIDTH  rs operand; it is the source for mthi/mtlo.
- B  input  WIDTH  rt operand.
- Hi  output  WIDTH  current HI register (feeds ALU HI_in).
- Lo  output  WIDTH  current LO register (feeds ALU LO_in).
- Busy  output  1  multiply in progress; the pipeline stalls any HI/LO-touching instruction while this is high.
- Done  output  1  one-cycle pulse in the cycle after HI/LO take a multiply result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Hi=0, Lo=0, Busy=0, Done=0, state IDLE.
  - Any in-flight multiply is discarded and HI/LO are not written.
- States: IDLE, MUL, FIN.
- IDLE:
  - Start=1 with Op=1: Hi<=A at that edge. No Busy, no Done; Lo unchanged.
  - Start=1 with Op=2: Lo<=A at that edge. No Busy, no Done; Hi unchanged.
  - Start=1 with Op in 3..6, at edge k:
    - Capture A, B and Op.
    - For signed ops, load operand magnitudes and record sign = A[31]^B[31].
    - Clear the 64-bit product accumulator and step counter; go to MUL. Busy=1 from edge k.
  - Start=0, or Op in {0,7}: no action.
- MUL:
  - Each cycle: if multiplier LSB=1, add the multiplicand (zero-extended) to the upper product half; shift the multiplier right 1; shift the product per the standard shift-add scheme; counter+1.
  - After WIDTH cycles go to FIN (edge k+32).
- FIN (one cycle; the update happens at edge k+33):
  - P = unsigned product, negated (two's complement, 64-bit) if the signed op's sign=1.
  - mult/multu: {Hi,Lo}<=P.
  - madd: {Hi,Lo}<={Hi,Lo}+P.
  - msub: {Hi,Lo}<={Hi,Lo}-P.
  - Arithmetic is modulo 2^64; there is no overflow flag or trap.
  - Busy<=0 and Done<=1 at edge k+33; Done returns to 0 at edge k+34.
  - Go to IDLE.
- Latency:
  - Multiply results are visible on Hi/Lo 33 cycles after the Start edge.
  - mthi/mtlo results are visible 1 cycle after the Start edge.
- Start while Busy=1: ignored, whatever Op is. Operand changes on A/B during MUL/FIN have no effect.
- Start in the same cycle as FIN's completion edge: Busy is still 1 at that edge, so it is ignored. The next Start is accepted from edge k+34 onward.
- Hi/Lo are driven straight from the registers, with no combinational bypass. A value written at edge n is readable from edge n onward.
- madd/msub accumulate against the Hi/Lo values present at edge k+33, not those present at Start. This is equivalent, since writes are blocked while Busy.
- Signed magnitude of -2^31 is 2^31, represented correctly in the 33-bit-safe unsigned path.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle -> Hi=0, Lo=0, Busy=0, Done=0 immediately, without waiting for Clk.
- mthi/mtlo:
  - Start, Op=1, A=0x12345678 -> Hi=0x12345678 next edge, Lo unchanged, Busy stays 0.
  - Then Op=2, A=0xCAFEF00D -> Lo=0xCAFEF00D.
- multu: A=B=0xFFFFFFFF -> Busy high 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001, and a single-cycle Done pulse.
- Signed mult:
  - A=0xFFFFFFFE (-2), B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
  - A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0.
- madd/msub:
  - With Hi=0, Lo=5: madd A=3, B=4 -> Hi=0, Lo=0x11.
  - Then with Hi=Lo=0: msub A=1, B=1 -> Hi=Lo=0xFFFFFFFF (wrap).
- Start during Busy, and reset mid-op:
  - Issue mthi A=0xDEAD at cycle 10 of a multiply -> ignored; Hi ends as the multiply result.
  - Separately, pulse Reset at cycle 20 of a mult -> Hi=Lo=0, no Done pulse ever appears.
